// File: rtl/rs_entry_array.sv
// Reservation-station entry storage: allocation into the lowest free slot,
// tag wakeup, per-entry age stamping and dual-slot issue from selector grants.
module rs_entry_array #(
  parameter int RS_SIZE        = 4,
  parameter int RS_INDEX_WIDTH = 2,
  parameter int AGE_WIDTH      = 16,
  parameter int TAG_WIDTH      = 6,
  parameter int PAYLOAD_WIDTH  = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  alloc_valid_i,
  output logic                                  alloc_ready_o,
  input  logic [TAG_WIDTH-1:0]                  alloc_src1_tag_i,
  input  logic [TAG_WIDTH-1:0]                  alloc_src2_tag_i,
  input  logic                                  alloc_src1_rdy_i,
  input  logic                                  alloc_src2_rdy_i,
  input  logic [PAYLOAD_WIDTH-1:0]              alloc_payload_i,
  input  logic                                  wakeup_valid_i,
  input  logic [TAG_WIDTH-1:0]                  wakeup_tag_i,
  output logic [RS_SIZE-1:0]                    ready_o,
  output logic [RS_SIZE-1:0][AGE_WIDTH-1:0]     ages_o,
  input  logic                                  first_valid_i,
  input  logic                                  second_valid_i,
  input  logic [RS_INDEX_WIDTH-1:0]             first_index_i,
  input  logic [RS_INDEX_WIDTH-1:0]             second_index_i,
  output logic                                  issue0_valid_o,
  output logic                                  issue1_valid_o,
  output logic [PAYLOAD_WIDTH-1:0]              issue0_payload_o,
  output logic [PAYLOAD_WIDTH-1:0]              issue1_payload_o,
  output logic [RS_INDEX_WIDTH:0]               count_o
);

  // Allocation stops one below all-ones so the all-ones age (the "invalid"
  // marker seen by the selector) can never be stamped into an entry.
  localparam logic [AGE_WIDTH-1:0] AGE_LIMIT = {{(AGE_WIDTH-1){1'b1}}, 1'b0};

  logic [RS_SIZE-1:0]        valid_q, valid_d;
  logic [RS_SIZE-1:0]        src1_rdy_q, src1_rdy_d;
  logic [RS_SIZE-1:0]        src2_rdy_q, src2_rdy_d;
  logic [TAG_WIDTH-1:0]      src1_tag_q [RS_SIZE];
  logic [TAG_WIDTH-1:0]      src2_tag_q [RS_SIZE];
  logic [PAYLOAD_WIDTH-1:0]  payload_q  [RS_SIZE];
  logic [AGE_WIDTH-1:0]      age_q      [RS_SIZE];
  logic [AGE_WIDTH-1:0]      age_cnt_q, age_cnt_d;

  logic                      free_found;
  logic [RS_INDEX_WIDTH-1:0] free_idx;
  logic                      alloc_fire;
  logic                      alloc_src1_rdy;
  logic                      alloc_src2_rdy;

  // Lowest-index free entry, looked up in registered state only so an entry
  // freed by issue this cycle is not handed out until the next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = RS_INDEX_WIDTH'(i);
      end
    end
  end

  assign alloc_ready_o  = free_found && (age_cnt_q != AGE_LIMIT) && !flush_i;
  assign alloc_fire     = alloc_valid_i && alloc_ready_o;
  // A result broadcast in the allocation cycle would otherwise be missed.
  assign alloc_src1_rdy = alloc_src1_rdy_i || (wakeup_valid_i && (alloc_src1_tag_i == wakeup_tag_i));
  assign alloc_src2_rdy = alloc_src2_rdy_i || (wakeup_valid_i && (alloc_src2_tag_i == wakeup_tag_i));

  assign ready_o = valid_q & src1_rdy_q & src2_rdy_q;

  // Issue slots: grants to non-ready entries are dropped; slot 1 yields to slot 0 on a duplicate index.
  always_comb begin
    issue0_valid_o   = !flush_i && first_valid_i && ready_o[first_index_i];
    issue1_valid_o   = !flush_i && second_valid_i && ready_o[second_index_i]
                       && ((second_index_i != first_index_i) || !first_valid_i);
    issue0_payload_o = payload_q[first_index_i];
    issue1_payload_o = payload_q[second_index_i];
  end

  // Per-entry age as presented to the selector; empty slots read as youngest-possible (all-ones).
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ages_o[i] = valid_q[i] ? age_q[i] : {AGE_WIDTH{1'b1}};
    end
  end

  // Occupancy count from registered valid bits.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      count_o = count_o + (RS_INDEX_WIDTH + 1)'(valid_q[i]);
    end
  end

  // Next-state for valid/ready bits and the age counter; flush overrides everything.
  always_comb begin
    valid_d    = valid_q;
    src1_rdy_d = src1_rdy_q;
    src2_rdy_d = src2_rdy_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (valid_q[i] && wakeup_valid_i && (src1_tag_q[i] == wakeup_tag_i)) src1_rdy_d[i] = 1'b1;
      if (valid_q[i] && wakeup_valid_i && (src2_tag_q[i] == wakeup_tag_i)) src2_rdy_d[i] = 1'b1;
      if ((issue0_valid_o && (first_index_i == RS_INDEX_WIDTH'(i))) ||
          (issue1_valid_o && (second_index_i == RS_INDEX_WIDTH'(i)))) begin
        valid_d[i] = 1'b0;
      end
      if (alloc_fire && (free_idx == RS_INDEX_WIDTH'(i))) begin
        valid_d[i]    = 1'b1;
        src1_rdy_d[i] = alloc_src1_rdy;
        src2_rdy_d[i] = alloc_src2_rdy;
      end
    end
    if (flush_i) valid_d = '0;

    // The counter restarts once the array drains so ages stay compact.
    if (flush_i)              age_cnt_d = '0;
    else if (alloc_fire)      age_cnt_d = age_cnt_q + 1'b1;
    else if (valid_d == '0)   age_cnt_d = '0;
    else                      age_cnt_d = age_cnt_q;
  end

  // Control state: valid/ready bits and age counter, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      age_cnt_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      src1_rdy_q <= src1_rdy_d;
      src2_rdy_q <= src2_rdy_d;
      age_cnt_q  <= age_cnt_d;
    end
  end

  // Entry data is only meaningful while valid, so it is written on allocation and never reset.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      src1_tag_q[free_idx] <= alloc_src1_tag_i;
      src2_tag_q[free_idx] <= alloc_src2_tag_i;
      payload_q[free_idx]  <= alloc_payload_i;
      age_q[free_idx]      <= age_cnt_q;
    end
  end

endmodule

// File: tb/tb_rs_entry_array.sv
// Bench for rs_entry_array (AGE_WIDTH=3 so age-limit behaviour is reachable)
// with a slot-level reference model of entries and the age counter.
module tb_rs_entry_array;
  localparam int N = 4, IW = 2, AW = 3, TW = 6, PW = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic flush_i, alloc_valid_i, alloc_ready_o;
  logic [TW-1:0] alloc_src1_tag_i, alloc_src2_tag_i;
  logic alloc_src1_rdy_i, alloc_src2_rdy_i;
  logic [PW-1:0] alloc_payload_i;
  logic wakeup_valid_i;
  logic [TW-1:0] wakeup_tag_i;
  logic [N-1:0] ready_o;
  logic [N-1:0][AW-1:0] ages_o;
  logic first_valid_i, second_valid_i;
  logic [IW-1:0] first_index_i, second_index_i;
  logic issue0_valid_o, issue1_valid_o;
  logic [PW-1:0] issue0_payload_o, issue1_payload_o;
  logic [IW:0] count_o;

  always #5 clk_i = ~clk_i;

  rs_entry_array #(.RS_SIZE(N), .RS_INDEX_WIDTH(IW), .AGE_WIDTH(AW), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_src1_tag_i(alloc_src1_tag_i), .alloc_src2_tag_i(alloc_src2_tag_i),
    .alloc_src1_rdy_i(alloc_src1_rdy_i), .alloc_src2_rdy_i(alloc_src2_rdy_i),
    .alloc_payload_i(alloc_payload_i),
    .wakeup_valid_i(wakeup_valid_i), .wakeup_tag_i(wakeup_tag_i),
    .ready_o(ready_o), .ages_o(ages_o),
    .first_valid_i(first_valid_i), .second_valid_i(second_valid_i),
    .first_index_i(first_index_i), .second_index_i(second_index_i),
    .issue0_valid_o(issue0_valid_o), .issue1_valid_o(issue1_valid_o),
    .issue0_payload_o(issue0_payload_o), .issue1_payload_o(issue1_payload_o),
    .count_o(count_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0][AW-1:0] all_ones_ages;

  // Reference model state
  bit m_v [N];
  bit m_r1 [N];
  bit m_r2 [N];
  logic [TW-1:0] m_t1 [N];
  logic [TW-1:0] m_t2 [N];
  logic [PW-1:0] m_p [N];
  int m_age [N];
  int m_ctr;

  // Model predictions for the current cycle
  bit e_ar, e_i0v, e_i1v;
  logic [N-1:0] e_rdy;
  logic [N-1:0][AW-1:0] e_ages;
  logic [PW-1:0] e_i0p, e_i1p;
  int e_cnt, e_free;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_ctr = 0;
  endfunction

  function automatic void model_eval();
    e_free = -1;
    e_cnt  = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_v[i] && e_free < 0) e_free = i;
      if (m_v[i]) e_cnt++;
      e_rdy[i]  = m_v[i] && m_r1[i] && m_r2[i];
      e_ages[i] = m_v[i] ? AW'(m_age[i]) : {AW{1'b1}};
    end
    e_ar  = (e_free >= 0) && (m_ctr != (1 << AW) - 2) && !flush_i;
    e_i0v = !flush_i && first_valid_i && e_rdy[first_index_i];
    e_i1v = !flush_i && second_valid_i && e_rdy[second_index_i]
            && (second_index_i != first_index_i || !first_valid_i);
    e_i0p = m_p[first_index_i];
    e_i1p = m_p[second_index_i];
  endfunction

  function automatic void model_step();
    bit fire, any;
    int k;
    if (flush_i) begin
      model_reset();
      return;
    end
    fire = alloc_valid_i && e_ar;
    k = e_free;
    if (wakeup_valid_i) begin
      for (int i = 0; i < N; i++) begin
        if (m_v[i] && m_t1[i] == wakeup_tag_i) m_r1[i] = 1'b1;
        if (m_v[i] && m_t2[i] == wakeup_tag_i) m_r2[i] = 1'b1;
      end
    end
    if (e_i0v) m_v[first_index_i] = 1'b0;
    if (e_i1v) m_v[second_index_i] = 1'b0;
    if (fire) begin
      m_v[k]   = 1'b1;
      m_t1[k]  = alloc_src1_tag_i;
      m_t2[k]  = alloc_src2_tag_i;
      m_r1[k]  = alloc_src1_rdy_i || (wakeup_valid_i && alloc_src1_tag_i == wakeup_tag_i);
      m_r2[k]  = alloc_src2_rdy_i || (wakeup_valid_i && alloc_src2_tag_i == wakeup_tag_i);
      m_p[k]   = alloc_payload_i;
      m_age[k] = m_ctr;
      m_ctr++;
    end else begin
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= m_v[i];
      if (!any) m_ctr = 0;
    end
  endfunction

  task automatic idle();
    flush_i = 0; alloc_valid_i = 0; alloc_src1_tag_i = '0; alloc_src2_tag_i = '0;
    alloc_src1_rdy_i = 0; alloc_src2_rdy_i = 0; alloc_payload_i = '0;
    wakeup_valid_i = 0; wakeup_tag_i = '0;
    first_valid_i = 0; second_valid_i = 0; first_index_i = '0; second_index_i = '0;
  endtask

  task automatic alloc_in(input logic [TW-1:0] t1, input bit r1, input logic [TW-1:0] t2, input bit r2,
                          input logic [PW-1:0] p);
    alloc_valid_i = 1; alloc_src1_tag_i = t1; alloc_src1_rdy_i = r1;
    alloc_src2_tag_i = t2; alloc_src2_rdy_i = r2; alloc_payload_i = p;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    model_reset();
    #12;
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    n_cmp++; if (ready_o !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b expected 0000", ready_o); end
    n_cmp++; if (ages_o !== all_ones_ages) begin n_bad++; $display("FAIL reset_ages: got %h expected %h", ages_o, all_ones_ages); end
    rst_ni = 1'b1;
    settle();
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready_o); end
    step();
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      idle();
      alloc_in(6'(k), 1, 6'(k + 8), 1, 32'hA000_0000 + k);
      settle();
      n_cmp++; if (alloc_ready_o !== 1'b1) begin n_bad++; $display("FAIL fill_ready_%0d: got %b expected 1", k, alloc_ready_o); end
      step();
    end
    idle();
    settle();
    n_cmp++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d expected 4", count_o); end
    n_cmp++; if (ready_o !== 4'b1111) begin n_bad++; $display("FAIL fill_ready_vec: got %b expected 1111", ready_o); end
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_bad++; $display("FAIL fill_full_alloc_ready: got %b expected 0", alloc_ready_o); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (ages_o[k] !== AW'(k)) begin n_bad++; $display("FAIL fill_age_%0d: got %0d expected %0d", k, ages_o[k], k); end
      first_index_i = IW'(k);
      settle();
      n_cmp++; if (issue0_payload_o !== 32'hA000_0000 + k) begin n_bad++; $display("FAIL fill_payload_%0d: got %h expected %h", k, issue0_payload_o, 32'hA000_0000 + k); end
    end
    idle();
  endtask

  task automatic test_same_index_grant();
    idle();
    first_valid_i = 1; second_valid_i = 1; first_index_i = 2'd2; second_index_i = 2'd2;
    alloc_in(6'd1, 1, 6'd2, 1, 32'hBEEF_0002);
    settle();
    n_cmp++; if (issue0_valid_o !== 1'b1) begin n_bad++; $display("FAIL dup_issue0: got %b expected 1", issue0_valid_o); end
    n_cmp++; if (issue1_valid_o !== 1'b0) begin n_bad++; $display("FAIL dup_issue1: got %b expected 0", issue1_valid_o); end
    n_cmp++; if (issue0_payload_o !== 32'hA000_0002) begin n_bad++; $display("FAIL dup_payload: got %h expected a0000002", issue0_payload_o); end
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_bad++; $display("FAIL dup_no_same_cycle_reuse: got %b expected 0", alloc_ready_o); end
    step();
    first_valid_i = 0; second_valid_i = 0;
    settle();
    n_cmp++; if (count_o !== 3'd3) begin n_bad++; $display("FAIL dup_count: got %0d expected 3", count_o); end
    n_cmp++; if (ready_o !== 4'b1011) begin n_bad++; $display("FAIL dup_ready_vec: got %b expected 1011", ready_o); end
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_bad++; $display("FAIL dup_alloc_ready: got %b expected 1", alloc_ready_o); end
    step();
    idle();
    first_index_i = 2'd2;
    settle();
    n_cmp++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL dup_refill_count: got %0d expected 4", count_o); end
    n_cmp++; if (ages_o[2] !== 3'd4) begin n_bad++; $display("FAIL dup_refill_age: got %0d expected 4", ages_o[2]); end
    n_cmp++; if (issue0_payload_o !== 32'hBEEF_0002) begin n_bad++; $display("FAIL dup_refill_slot: got %h expected beef0002", issue0_payload_o); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    flush_i = 1; wakeup_valid_i = 1; wakeup_tag_i = 6'd3;
    first_valid_i = 1; first_index_i = 2'd0; second_valid_i = 1; second_index_i = 2'd1;
    alloc_in(6'd3, 1, 6'd3, 1, 32'h1111_1111);
    settle();
    n_cmp++; if (issue0_valid_o !== 1'b0 || issue1_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_issue: got %b%b expected 00", issue0_valid_o, issue1_valid_o); end
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_alloc_ready: got %b expected 0", alloc_ready_o); end
    step();
    idle();
    settle();
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    n_cmp++; if (ready_o !== 4'b0000) begin n_bad++; $display("FAIL flush_ready: got %b expected 0000", ready_o); end
    n_cmp++; if (ages_o !== all_ones_ages) begin n_bad++; $display("FAIL flush_ages: got %h expected %h", ages_o, all_ones_ages); end
    alloc_in(6'd1, 1, 6'd1, 1, 32'h2222_2222);
    step();
    idle();
    settle();
    n_cmp++; if (ages_o[0] !== 3'd0) begin n_bad++; $display("FAIL flush_age_restart: got %0d expected 0", ages_o[0]); end
    flush_i = 1;
    step();
    idle();
  endtask

  task automatic test_wakeup();
    idle();
    alloc_in(6'd5, 0, 6'd7, 1, 32'h5);
    step();
    idle();
    settle();
    n_cmp++; if (ready_o[0] !== 1'b0) begin n_bad++; $display("FAIL wake_pending: got %b expected 0", ready_o[0]); end
    wakeup_valid_i = 1; wakeup_tag_i = 6'd5;
    settle();
    n_cmp++; if (ready_o[0] !== 1'b0) begin n_bad++; $display("FAIL wake_no_bypass: got %b expected 0", ready_o[0]); end
    step();
    idle();
    settle();
    n_cmp++; if (ready_o[0] !== 1'b1) begin n_bad++; $display("FAIL wake_after_edge: got %b expected 1", ready_o[0]); end
    alloc_in(6'd9, 1, 6'd5, 0, 32'h6);
    wakeup_valid_i = 1; wakeup_tag_i = 6'd5;
    settle();
    n_cmp++; if (ready_o[1] !== 1'b0) begin n_bad++; $display("FAIL wake_alloc_before: got %b expected 0", ready_o[1]); end
    step();
    idle();
    settle();
    n_cmp++; if (ready_o[1] !== 1'b1) begin n_bad++; $display("FAIL wake_alloc_same_cycle: got %b expected 1", ready_o[1]); end
    alloc_in(6'd12, 0, 6'd4, 1, 32'h7);
    wakeup_valid_i = 1; wakeup_tag_i = 6'd13;
    step();
    alloc_valid_i = 0;
    step();
    idle();
    settle();
    n_cmp++; if (ready_o[2] !== 1'b0) begin n_bad++; $display("FAIL wake_wrong_tag: got %b expected 0", ready_o[2]); end
    flush_i = 1;
    step();
    idle();
  endtask

  task automatic test_age_limit();
    int prev, idx;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      idle();
      alloc_in(6'd0, 1, 6'd0, 1, 32'(k));
      if (prev >= 0) begin first_valid_i = 1; first_index_i = IW'(prev); end
      settle();
      n_cmp++; if (alloc_ready_o !== 1'b1) begin n_bad++; $display("FAIL age_ready_%0d: got %b expected 1", k, alloc_ready_o); end
      idx = e_free;
      step();
      n_cmp++; if (ages_o[idx] !== AW'(k)) begin n_bad++; $display("FAIL age_stamp_%0d: got %0d expected %0d", k, ages_o[idx], k); end
      prev = idx;
    end
    idle();
    alloc_in(6'd0, 1, 6'd0, 1, 32'h99);
    first_valid_i = 1; first_index_i = IW'(prev);
    settle();
    n_cmp++; if (alloc_ready_o !== 1'b0) begin n_bad++; $display("FAIL age_limit_block: got %b expected 0", alloc_ready_o); end
    step();
    idle();
    settle();
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL age_drain_count: got %0d expected 0", count_o); end
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_bad++; $display("FAIL age_drain_ready: got %b expected 1", alloc_ready_o); end
    alloc_in(6'd0, 1, 6'd0, 1, 32'h77);
    idx = e_free;
    step();
    n_cmp++; if (ages_o[idx] !== 3'd0) begin n_bad++; $display("FAIL age_restart: got %0d expected 0", ages_o[idx]); end
    idle();
    flush_i = 1;
    step();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush_i          = ($urandom_range(0, 31) == 0);
      alloc_valid_i    = ($urandom_range(0, 3) != 0);
      alloc_src1_tag_i = TW'($urandom_range(0, 7));
      alloc_src2_tag_i = TW'($urandom_range(0, 7));
      alloc_src1_rdy_i = $urandom_range(0, 1) == 1;
      alloc_src2_rdy_i = $urandom_range(0, 1) == 1;
      alloc_payload_i  = $urandom;
      wakeup_valid_i   = $urandom_range(0, 1) == 1;
      wakeup_tag_i     = TW'($urandom_range(0, 7));
      first_valid_i    = $urandom_range(0, 1) == 1;
      second_valid_i   = $urandom_range(0, 1) == 1;
      first_index_i    = IW'($urandom_range(0, N - 1));
      second_index_i   = IW'($urandom_range(0, N - 1));
      settle();
      n_cmp++; if (alloc_ready_o !== e_ar) begin n_bad++; $display("FAIL rnd_alloc_ready c=%0d: got %b expected %b", c, alloc_ready_o, e_ar); end
      n_cmp++; if (ready_o !== e_rdy) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, ready_o, e_rdy); end
      n_cmp++; if (ages_o !== e_ages) begin n_bad++; $display("FAIL rnd_ages c=%0d: got %h expected %h", c, ages_o, e_ages); end
      n_cmp++; if (count_o !== 3'(e_cnt)) begin n_bad++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, count_o, e_cnt); end
      n_cmp++; if (issue0_valid_o !== e_i0v || issue1_valid_o !== e_i1v) begin n_bad++; $display("FAIL rnd_issue_valid c=%0d: got %b%b expected %b%b", c, issue0_valid_o, issue1_valid_o, e_i0v, e_i1v); end
      if (e_i0v) begin
        n_cmp++; if (issue0_payload_o !== e_i0p) begin n_bad++; $display("FAIL rnd_issue0_payload c=%0d: got %h expected %h", c, issue0_payload_o, e_i0p); end
      end
      if (e_i1v) begin
        n_cmp++; if (issue1_payload_o !== e_i1p) begin n_bad++; $display("FAIL rnd_issue1_payload c=%0d: got %h expected %h", c, issue1_payload_o, e_i1p); end
      end
      step();
    end
    idle();
    flush_i = 1;
    step();
    idle();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      alloc_in(6'd1, 1, 6'd2, 1, 32'hC0 + k);
      step();
    end
    idle();
    first_valid_i = 1; first_index_i = 2'd1;
    settle();
    n_cmp++; if (issue0_valid_o !== 1'b1) begin n_bad++; $display("FAIL arst_pre_issue: got %b expected 1", issue0_valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL arst_count: got %0d expected 0", count_o); end
    n_cmp++; if (ready_o !== 4'b0000) begin n_bad++; $display("FAIL arst_ready: got %b expected 0000", ready_o); end
    n_cmp++; if (ages_o !== all_ones_ages) begin n_bad++; $display("FAIL arst_ages: got %h expected %h", ages_o, all_ones_ages); end
    n_cmp++; if (issue0_valid_o !== 1'b0 || issue1_valid_o !== 1'b0) begin n_bad++; $display("FAIL arst_issue: got %b%b expected 00", issue0_valid_o, issue1_valid_o); end
    model_reset();
    idle();
    rst_ni = 1'b1;
    settle();
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_bad++; $display("FAIL arst_release_ready: got %b expected 1", alloc_ready_o); end
    step();
  endtask

  initial begin
    all_ones_ages = '1;
    test_reset();
    test_fill();
    test_same_index_grant();
    test_flush();
    test_wakeup();
    test_age_limit();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
